// File: rtl/ifu_pc_gen_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
package ifu_pc_gen_pkg;

  localparam int REG_W = 32;
  localparam logic [REG_W-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int QDEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [REG_W-1:0] pc;
    logic [31:0]      inst;
    logic             pred_taken;
    logic [REG_W-1:0] pred_target;
  } fq_entry_t;

  function automatic logic [REG_W-1:0] word_align(input logic [REG_W-1:0] pc);
    return pc & ~REG_W'(3);
  endfunction

endpackage

// File: rtl/ifu_pc_gen_fetch_queue.sv
// Two-entry FIFO between fetch and ID; clear beats push and pop in the same cycle.
module ifu_pc_gen_fetch_queue
  import ifu_pc_gen_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push,
  input  fq_entry_t push_data,
  input  logic      pop,
  input  logic      clear,
  output fq_entry_t head,
  output logic [1:0] count
);

  fq_entry_t mem [QDEPTH];
  logic      wr_ptr;
  logic      rd_ptr;
  logic      push_eff;
  logic      pop_eff;

  assign push_eff = push && !clear;
  assign pop_eff  = pop && !clear && (count != 2'd0);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!rst_i || clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_eff) wr_ptr <= ~wr_ptr;
      if (pop_eff)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_eff} - {1'b0, pop_eff};
    end
  end

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_eff) mem[wr_ptr] <= push_data;
  end

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_i)
    !(push_eff && !pop_eff && count == 2'(QDEPTH)));

endmodule

// File: rtl/ifu_pc_gen.sv
// Fetch PC sequencer: single-outstanding imem requests, next-PC selection from the
// predictor, mispredict redirect with wrong-path kill, and a 2-entry queue toward ID.
//
// state | meaning
// IDLE  | no request outstanding; waits for queue space
// REQ   | request outstanding at fetch_pc (imem_req_o high)
// KILL  | redirected while a request was outstanding; next response is discarded
module ifu_pc_gen
  import ifu_pc_gen_pkg::*;
#(
  parameter logic [REG_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [REG_W-1:0] pd_pc_o,
  input  logic             pd_taken_i,
  input  logic [REG_W-1:0] pd_targetPc_i,
  input  logic             pd_failed_i,
  input  logic [REG_W-1:0] pd_flushPc_i,
  output logic             imem_req_o,
  output logic [REG_W-1:0] imem_addr_o,
  input  logic             imem_resp_i,
  input  logic [31:0]      imem_rdata_i,
  output logic             id_valid_o,
  input  logic             id_ready_i,
  output logic [REG_W-1:0] id_pc_o,
  output logic [31:0]      id_inst_o,
  output logic             id_predTaken_o,
  output logic [REG_W-1:0] id_predTarget_o
);

  fetch_state_e     state;
  logic [REG_W-1:0] fetch_pc;
  logic             req_q;
  logic [1:0]       q_count;
  logic [1:0]       post_count;
  logic             q_pop;
  logic             accept_resp;
  fq_entry_t        q_wdata;
  fq_entry_t        q_head;

  assign pd_pc_o     = fetch_pc;
  assign imem_addr_o = fetch_pc;
  assign imem_req_o  = req_q;

  assign id_valid_o      = (q_count != 2'd0);
  assign id_pc_o         = q_head.pc;
  assign id_inst_o       = q_head.inst;
  assign id_predTaken_o  = q_head.pred_taken;
  assign id_predTarget_o = q_head.pred_target;

  assign q_pop       = id_valid_o && id_ready_i;
  assign accept_resp = (state == ST_REQ) && imem_resp_i && !pd_failed_i;
  assign post_count  = q_count + 2'd1 - {1'b0, q_pop};

  // The prediction is sampled in the response cycle, when pd_pc_o still names this fetch.
  assign q_wdata = '{
    pc:          fetch_pc,
    inst:        imem_rdata_i,
    pred_taken:  pd_taken_i,
    pred_target: pd_targetPc_i
  };

  ifu_pc_gen_fetch_queue u_fetch_queue (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (accept_resp),
    .push_data (q_wdata),
    .pop       (q_pop),
    .clear     (pd_failed_i),
    .head      (q_head),
    .count     (q_count)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      req_q    <= 1'b0;
      fetch_pc <= RESET_PC;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pd_failed_i || q_count < 2'd2) begin
            state <= ST_REQ;
            req_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (pd_failed_i && !imem_resp_i) begin
            state <= ST_KILL;
            req_q <= 1'b0;
          end else if (accept_resp && post_count == 2'd2) begin
            state <= ST_IDLE;
            req_q <= 1'b0;
          end
        end
        // A response coinciding with another redirect still retires the stale request.
        ST_KILL: begin
          if (imem_resp_i) begin
            state <= ST_REQ;
            req_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          req_q <= 1'b0;
        end
      endcase

      if (pd_failed_i)
        fetch_pc <= word_align(pd_flushPc_i);
      else if (accept_resp)
        fetch_pc <= pd_taken_i ? word_align(pd_targetPc_i) : fetch_pc + REG_W'(4);
    end
  end

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Bench for ifu_pc_gen: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based behavioural model.
module tb_ifu_pc_gen;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pd_taken_i, pd_failed_i, imem_resp_i, id_ready_i;
  logic [31:0] pd_targetPc_i, pd_flushPc_i, imem_rdata_i;
  logic [31:0] pd_pc_o, imem_addr_o, id_pc_o, id_inst_o, id_predTarget_o;
  logic        imem_req_o, id_valid_o, id_predTaken_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk_i = ~clk_i;

  ifu_pc_gen dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pd_pc_o         (pd_pc_o),
    .pd_taken_i      (pd_taken_i),
    .pd_targetPc_i   (pd_targetPc_i),
    .pd_failed_i     (pd_failed_i),
    .pd_flushPc_i    (pd_flushPc_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_resp_i     (imem_resp_i),
    .imem_rdata_i    (imem_rdata_i),
    .id_valid_o      (id_valid_o),
    .id_ready_i      (id_ready_i),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .id_predTaken_o  (id_predTaken_o),
    .id_predTarget_o (id_predTarget_o)
  );

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endfunction

  // Behavioural model: what ID should see, where fetch should point, whether a
  // request should be live, and whether a killed response is still owed.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        tk;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_req, m_stale, m_live = 0;
  int          m_cnt;

  always @(posedge clk_i) begin
    if (!rst_i) begin
      m_live  = 1;
      m_pc    = RST_PC;
      m_req   = 0;
      m_stale = 0;
      mq.delete();
    end else if (m_live) begin
      if (pd_failed_i) begin
        if (m_stale && imem_resp_i) m_stale = 0;
        else if (m_req && !imem_resp_i) m_stale = 1;
        mq.delete();
        m_pc  = pd_flushPc_i & ~32'h3;
        m_req = !m_stale;
      end else begin
        m_cnt = mq.size();
        if (m_cnt > 0 && id_ready_i) void'(mq.pop_front());
        if (imem_resp_i && m_stale) begin
          m_stale = 0;
          m_req   = 1;
        end else if (imem_resp_i && m_req) begin
          mq.push_back('{m_pc, imem_rdata_i, pd_taken_i, pd_targetPc_i});
          m_pc  = pd_taken_i ? (pd_targetPc_i & ~32'h3) : m_pc + 32'd4;
          m_req = (mq.size() < 2);
        end else if (!m_req && !m_stale) begin
          m_req = (m_cnt < 2);
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (m_live) begin
      check("imem_req", imem_req_o, m_req);
      check("pd_pc", pd_pc_o, m_pc);
      check("imem_addr", imem_addr_o, m_pc);
      check("id_valid", id_valid_o, mq.size() > 0);
      if (mq.size() > 0) begin
        check("id_pc", id_pc_o, mq[0].pc);
        check("id_inst", id_inst_o, mq[0].inst);
        check("id_predTaken", id_predTaken_o, mq[0].tk);
        check("id_predTarget", id_predTarget_o, mq[0].tgt);
      end
    end
  end

  task automatic beat();
    @(negedge clk_i);
  endtask

  task automatic set_in(input bit r, input bit resp, input logic [31:0] rd,
                        input bit tk, input logic [31:0] tgt,
                        input bit fl, input logic [31:0] fpc, input bit rdy);
    #1;
    rst_i         = r;
    imem_resp_i   = resp;
    imem_rdata_i  = rd;
    pd_taken_i    = tk;
    pd_targetPc_i = tgt;
    pd_failed_i   = fl;
    pd_flushPc_i  = fpc;
    id_ready_i    = rdy;
  endtask

  bit got_req;

  initial begin
    rst_i = 0; imem_resp_i = 0; imem_rdata_i = 0; pd_taken_i = 0;
    pd_targetPc_i = 0; pd_failed_i = 0; pd_flushPc_i = 0; id_ready_i = 1;

    // Reset hold, then release.
    repeat (3) @(posedge clk_i);
    beat();
    check("rst_req", imem_req_o, 1'b0);
    check("rst_valid", id_valid_o, 1'b0);
    set_in(1, 0, 0, 0, 0, 0, 0, 1);
    got_req = 0;
    for (int i = 0; i < 2 && !got_req; i++) begin
      beat();
      if (imem_req_o) got_req = 1;
    end
    check("release_req", got_req, 1'b1);
    check("release_addr", imem_addr_o, 32'h8000_0000);

    // Sequential fetch, response one cycle after each request.
    beat();
    check("seq_hold_addr", imem_addr_o, 32'h8000_0000);
    set_in(1, 1, 32'h1111_0000, 0, 0, 0, 0, 1);
    beat();
    check("seq_addr1", imem_addr_o, 32'h8000_0004);
    check("seq_id_pc0", id_pc_o, 32'h8000_0000);
    check("seq_id_inst0", id_inst_o, 32'h1111_0000);
    set_in(1, 0, 0, 0, 0, 0, 0, 1);
    beat();
    check("seq_popped", id_valid_o, 1'b0);
    set_in(1, 1, 32'h1111_0004, 0, 0, 0, 0, 1);
    beat();
    check("seq_addr2", imem_addr_o, 32'h8000_0008);
    check("seq_id_pc1", id_pc_o, 32'h8000_0004);
    set_in(1, 0, 0, 0, 0, 0, 0, 1);

    // Predicted taken at 0x80000008.
    beat();
    set_in(1, 1, 32'h1111_0008, 1, 32'h8000_0100, 0, 0, 1);
    beat();
    check("tk_addr", imem_addr_o, 32'h8000_0100);
    check("tk_id_pc", id_pc_o, 32'h8000_0008);
    check("tk_pred", id_predTaken_o, 1'b1);
    check("tk_target", id_predTarget_o, 32'h8000_0100);

    // Flush while waiting (unaligned flush PC); held head must vanish.
    set_in(1, 0, 0, 0, 0, 1, 32'h8000_0043, 0);
    beat();
    check("kill_valid", id_valid_o, 1'b0);
    check("kill_req", imem_req_o, 1'b0);
    set_in(1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    beat();
    check("kill_refetch_req", imem_req_o, 1'b1);
    check("kill_refetch_addr", imem_addr_o, 32'h8000_0040);
    check("kill_dropped", id_valid_o, 1'b0);

    // Flush coincident with a response.
    set_in(1, 1, 32'hBAD0_BAD0, 0, 0, 1, 32'h8000_0200, 0);
    beat();
    check("coinc_req", imem_req_o, 1'b1);
    check("coinc_addr", imem_addr_o, 32'h8000_0200);
    check("coinc_valid", id_valid_o, 1'b0);

    // Backpressure.
    set_in(1, 1, 32'h2222_0200, 0, 0, 0, 0, 0);
    beat();
    check("bp_addr1", imem_addr_o, 32'h8000_0204);
    set_in(1, 1, 32'h2222_0204, 0, 0, 0, 0, 0);
    beat();
    check("bp_full_req", imem_req_o, 1'b0);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      beat();
      check("bp_stall_req", imem_req_o, 1'b0);
    end
    check("bp_head", id_pc_o, 32'h8000_0200);
    set_in(1, 0, 0, 0, 0, 0, 0, 1);
    beat();
    check("bp_one_pop", id_pc_o, 32'h8000_0204);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    beat();
    check("bp_resume_req", imem_req_o, 1'b1);
    check("bp_resume_addr", imem_addr_o, 32'h8000_0208);
    set_in(1, 1, 32'h2222_0208, 0, 0, 0, 0, 1);
    beat();
    check("bp_next_pc", id_pc_o, 32'h8000_0208);
    check("bp_next_inst", id_inst_o, 32'h2222_0208);
    set_in(1, 0, 0, 0, 0, 0, 0, 1);

    // Random traffic; memory answers only what is live or owed.
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] fpc;
      beat();
      fpc = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      set_in($urandom_range(0, 199) != 0,
             (m_req || m_stale) && ($urandom_range(0, 2) != 0),
             $urandom,
             $urandom_range(0, 3) == 0,
             $urandom,
             $urandom_range(0, 19) == 0,
             fpc,
             $urandom_range(0, 3) != 0);
    end
    beat();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
